// File: rtl/fc_pkg.sv
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared definitions for the fc_score_layer slice: class count,
//                score width, FSM state encoding and the weight-store index
//                convention (index N_IN addresses the bias).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_pkg;

    localparam int N_CLASS = 3;
    localparam int SCORE_W = 32;
    localparam int IDX_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        BIAS = 2'd2,
        OUT  = 2'd3
    } fc_state_t;

    // Address width needed to select one of n weights.
    function automatic int idx_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Write index addresses a weight.
    function automatic logic is_wgt_idx(input logic [IDX_W-1:0] idx, input int n_in);
        return ({1'b0, idx} < 9'(n_in));
    endfunction

    // Write index addresses the bias (one past the last weight).
    function automatic logic is_bias_idx(input logic [IDX_W-1:0] idx, input int n_in);
        return ({1'b0, idx} == 9'(n_in));
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_mac_lane.sv
// ============================================================================
//  Module      : fc_mac_lane
//  Description : One class lane of the score layer: weight/bias store,
//                signed multiply-accumulate, bias add and 32-bit narrowing.
//                Narrowing saturates when FC_SCORE_SAT_EN is defined and
//                wraps (keeps the low 32 bits) otherwise.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                i_feat              - signed feature of the current beat
//                i_rd_idx            - weight index for the current beat
//                i_first             - first beat: load product, drop old acc
//                i_acc_en            - later beat: add product to acc
//                i_bias_en           - latch acc + bias into the result
//                i_out_en            - register narrowed result as the score
//                i_wr_en/idx/data    - weight (idx < N_IN) or bias write
//                o_score             - registered 32-bit class score
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int FEAT_W = 16,
    parameter int WGT_W  = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FEAT_W-1:0]        i_feat,
    input  logic [idx_aw(N_IN)-1:0]  i_rd_idx,
    input  logic                     i_first,
    input  logic                     i_acc_en,
    input  logic                     i_bias_en,
    input  logic                     i_out_en,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_wr_idx,
    input  logic [SCORE_W-1:0]       i_wr_data,
    output logic [SCORE_W-1:0]       o_score
);

    localparam int c_AW = idx_aw(N_IN);
    localparam int c_PW = FEAT_W + WGT_W;

    logic [WGT_W-1:0]          r_wgt [N_IN];
    logic [SCORE_W-1:0]        r_bias;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   r_res;
    logic [SCORE_W-1:0]        r_score;

    logic [WGT_W-1:0]          w_wgt;
    logic [c_PW-1:0]           w_feat_ext;
    logic [c_PW-1:0]           w_wgt_ext;
    logic signed [c_PW-1:0]    w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic [SCORE_W-1:0]        w_score;

    // ------------------------------------------------------------------
    // Weight / bias store
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IN; k++) begin
                r_wgt[k] <= '0;
            end
            r_bias <= '0;
        end else if (i_wr_en) begin
            if (is_wgt_idx(i_wr_idx, N_IN)) begin
                r_wgt[i_wr_idx[c_AW-1:0]] <= i_wr_data[WGT_W-1:0];
            end else if (is_bias_idx(i_wr_idx, N_IN)) begin
                r_bias <= i_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Full-precision signed product, sign-extended into the accumulator.
    // Operands are widened first so the multiply is exactly c_PW bits.
    // ------------------------------------------------------------------
    assign w_wgt      = r_wgt[i_rd_idx];
    assign w_feat_ext = {{WGT_W{i_feat[FEAT_W-1]}}, i_feat};
    assign w_wgt_ext  = {{FEAT_W{w_wgt[WGT_W-1]}}, w_wgt};
    assign w_prod     = $signed(w_feat_ext) * $signed(w_wgt_ext);
    assign w_prod_ext = {{(ACC_W-c_PW){w_prod[c_PW-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-SCORE_W){r_bias[SCORE_W-1]}}, r_bias};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_res <= '0;
        end else begin
            if (i_first) begin
                r_acc <= w_prod_ext;
            end else if (i_acc_en) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (i_bias_en) begin
                r_res <= r_acc + w_bias_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Narrowing to the 32-bit score
    // ------------------------------------------------------------------
`ifdef FC_SCORE_SAT_EN
    logic w_ovf;

    // Result fits in 32 signed bits only if all bits above bit 30 agree.
    assign w_ovf = (r_res[ACC_W-1:SCORE_W-1] != {(ACC_W-SCORE_W+1){r_res[ACC_W-1]}});

    always_comb begin
        w_score = r_res[SCORE_W-1:0];
        if (w_ovf) begin
            w_score = r_res[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    logic w_unused_hi;

    // Wrap mode keeps only the low 32 bits; the upper bits are dropped.
    assign w_score     = r_res[SCORE_W-1:0];
    assign w_unused_hi = ^r_res[ACC_W-1:SCORE_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= '0;
        end else if (i_out_en) begin
            r_score <= w_score;
        end
    end

    assign o_score = r_score;

endmodule

`default_nettype wire

// File: rtl/fc_score_layer.sv
// ============================================================================
//  Module      : fc_score_layer
//  Description : Final fully-connected classifier layer. Consumes N_IN signed
//                features per frame over valid/ready, forms three dot
//                products against a runtime-loadable weight/bias store and
//                emits the three 32-bit scores with a one-cycle valid pulse.
//                Optional macro FC_SCORE_SAT_EN selects saturating narrowing
//                (default: two's-complement wrap).
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                feat_data/valid/last/ready - feature stream
//                w_wr_en/class/idx/data     - weight/bias write port
//                score_data                 - class i at [i*32 +: 32]
//                score_valid                - one-cycle score update pulse
//                frame_err                  - one-cycle feat_last mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_score_layer
    import fc_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int FEAT_W = 16,
    parameter int WGT_W  = 16,
    parameter int ACC_W  = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FEAT_W-1:0]          feat_data,
    input  logic                       feat_valid,
    input  logic                       feat_last,
    output logic                       feat_ready,
    input  logic                       w_wr_en,
    input  logic [1:0]                 w_wr_class,
    input  logic [IDX_W-1:0]           w_wr_idx,
    input  logic [SCORE_W-1:0]         w_wr_data,
    output logic [N_CLASS*SCORE_W-1:0] score_data,
    output logic                       score_valid,
    output logic                       frame_err
);

    localparam int               c_AW       = idx_aw(N_IN);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    fc_state_t         r_state;
    fc_state_t         w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              r_frame_err;
    logic              r_score_valid;

    logic              w_ready;
    logic              w_first;
    logic              w_acc_en;
    logic              w_err_nxt;
    logic              w_wr_ok;
    logic              w_is_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_frame_err   <= 1'b0;
            r_score_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_frame_err   <= w_err_nxt;
            r_score_valid <= (r_state == OUT);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control. r_idx is 0 whenever the FSM is in IDLE,
    // so the first beat always reads weight 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready     = 1'b0;
        w_first     = 1'b0;
        w_acc_en    = 1'b0;
        w_err_nxt   = 1'b0;
        w_wr_ok     = 1'b0;
        w_is_last   = (r_idx == c_LAST_IDX);

        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (feat_valid) begin
                    w_first = 1'b1;
                    if (feat_last) begin
                        // Last flag on beat 0 is always early: consume and drop.
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ACC;
                        w_idx_nxt   = c_IDX_ONE;
                    end
                end else begin
                    // Store updates only when no beat can be in flight.
                    w_wr_ok = 1'b1;
                end
            end
            ACC: begin
                w_ready = 1'b1;
                if (feat_valid) begin
                    w_acc_en = 1'b1;
                    if (w_is_last) begin
                        // A missing last flag is flagged but the frame completes.
                        w_state_nxt = BIAS;
                        w_idx_nxt   = '0;
                        w_err_nxt   = !feat_last;
                    end else if (feat_last) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_ONE;
                    end
                end
            end
            BIAS: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign feat_ready  = w_ready;
    assign frame_err   = r_frame_err;
    assign score_valid = r_score_valid;

    // ------------------------------------------------------------------
    // Per-class MAC lanes sharing the FSM and feature counter
    // ------------------------------------------------------------------
    for (genvar c = 0; c < N_CLASS; c++) begin : g_lane
        logic w_lane_wr;

        assign w_lane_wr = w_wr_en & w_wr_ok & (w_wr_class == 2'(c));

        fc_mac_lane #(
            .N_IN   (N_IN),
            .FEAT_W (FEAT_W),
            .WGT_W  (WGT_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_feat    (feat_data),
            .i_rd_idx  (r_idx[c_AW-1:0]),
            .i_first   (w_first),
            .i_acc_en  (w_acc_en),
            .i_bias_en (r_state == BIAS),
            .i_out_en  (r_state == OUT),
            .i_wr_en   (w_lane_wr),
            .i_wr_idx  (w_wr_idx),
            .i_wr_data (w_wr_data),
            .o_score   (score_data[c*SCORE_W +: SCORE_W])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_score_layer.sv
// ============================================================================
//  Module      : tb_fc_score_layer
//  Description : Directed self-checking bench for fc_score_layer with N_IN=4.
//                Expected scores are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_score_layer;

    localparam int N_IN   = 4;
    localparam int FEAT_W = 16;
    localparam int WGT_W  = 16;
    localparam int ACC_W  = 40;

    localparam logic [95:0] c_BASIC = {32'hFFFF_FFF6, 32'h0000_0014, 32'h0000_000A};
    localparam logic [95:0] c_BIAS  = {32'hFFFF_FFFD, 32'h0000_000F, 32'h0000_006E};
`ifdef FC_SCORE_SAT_EN
    localparam logic [95:0] c_SAT   = {3{32'h7FFF_FFFF}};
`else
    localparam logic [95:0] c_SAT   = {3{32'hFFFC_0004}};
`endif
    localparam logic [63:0] c_FEATS = {16'd4, 16'd3, 16'd2, 16'd1};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FEAT_W-1:0] feat_data;
    logic              feat_valid;
    logic              feat_last;
    logic              feat_ready;
    logic              w_wr_en;
    logic [1:0]        w_wr_class;
    logic [7:0]        w_wr_idx;
    logic [31:0]       w_wr_data;
    logic [95:0]       score_data;
    logic              score_valid;
    logic              frame_err;

    int n_cmp  = 0;
    int n_bad  = 0;
    int sv_cnt = 0;
    int er_cnt = 0;
    int e0;
    int s0;

    always #5 clk = ~clk;

    fc_score_layer #(
        .N_IN   (N_IN),
        .FEAT_W (FEAT_W),
        .WGT_W  (WGT_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .feat_data   (feat_data),
        .feat_valid  (feat_valid),
        .feat_last   (feat_last),
        .feat_ready  (feat_ready),
        .w_wr_en     (w_wr_en),
        .w_wr_class  (w_wr_class),
        .w_wr_idx    (w_wr_idx),
        .w_wr_data   (w_wr_data),
        .score_data  (score_data),
        .score_valid (score_valid),
        .frame_err   (frame_err)
    );

    always @(negedge clk) begin
        if (score_valid) sv_cnt++;
        if (frame_err)   er_cnt++;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk96(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] cls, input logic [7:0] idx, input logic [31:0] d);
        w_wr_en    = 1'b1;
        w_wr_class = cls;
        w_wr_idx   = idx;
        w_wr_data  = d;
        tick();
        w_wr_en    = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        int t = 0;
        while (!feat_ready && t < 8) begin
            tick();
            t++;
        end
        chk1("ready_before_beat", feat_ready, 1'b1);
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        tick();
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic frame4(input logic [63:0] feats, input logic [3:0] lasts, input int gap);
        for (int i = 0; i < 4; i++) begin
            beat(feats[i*16 +: 16], lasts[i]);
            if (i < 3) repeat (gap) tick();
        end
    endtask

    // Called 1 time unit after the edge that accepted the final beat.
    task automatic expect_score(input string tag, input logic [95:0] exp_s);
        chk1({tag, "_rdy_c0"}, feat_ready, 1'b0);
        chk1({tag, "_vld_c0"}, score_valid, 1'b0);
        tick();
        chk1({tag, "_rdy_c1"}, feat_ready, 1'b0);
        chk1({tag, "_vld_c1"}, score_valid, 1'b0);
        tick();
        chk1({tag, "_vld_c2"}, score_valid, 1'b1);
        chk1({tag, "_rdy_c2"}, feat_ready, 1'b1);
        chk96({tag, "_data"}, score_data, exp_s);
        tick();
        chk1({tag, "_vld_c3"}, score_valid, 1'b0);
        chk96({tag, "_hold"}, score_data, exp_s);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        feat_data  = '0;
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_class = '0;
        w_wr_idx   = '0;
        w_wr_data  = '0;
        repeat (2) tick();

        // Reset state
        chk96("rst_score", score_data, 96'h0);
        chk1("rst_valid", score_valid, 1'b0);
        chk1("rst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("idle_ready", feat_ready, 1'b1);

        // Weights: class0 = 1, class1 = 2, class2 = -1
        for (int i = 0; i < N_IN; i++) begin
            wr(2'd0, 8'(i), 32'd1);
            wr(2'd1, 8'(i), 32'd2);
            wr(2'd2, 8'(i), 32'hFFFF_FFFF);
        end

        // Basic frame
        e0 = er_cnt;
        frame4(c_FEATS, 4'b1000, 0);
        expect_score("basic", c_BASIC);
        chki("basic_no_err", er_cnt, e0);

        // Early last on beat 2: abort, then a correct frame
        e0 = er_cnt;
        s0 = sv_cnt;
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b1);
        chk1("early_err_pulse", frame_err, 1'b1);
        chk1("early_back_idle", feat_ready, 1'b1);
        tick();
        chk1("early_err_clear", frame_err, 1'b0);
        repeat (3) tick();
        chki("early_no_score", sv_cnt, s0);
        chki("early_err_count", er_cnt, e0 + 1);
        frame4(c_FEATS, 4'b1000, 0);
        expect_score("after_early", c_BASIC);

        // Missing last: error pulse, frame still completes
        e0 = er_cnt;
        frame4(c_FEATS, 4'b0000, 0);
        chk1("missing_err_pulse", frame_err, 1'b1);
        expect_score("missing", c_BASIC);
        chki("missing_err_count", er_cnt, e0 + 1);

        // Biases plus stalled stream
        wr(2'd0, 8'd4, 32'd100);
        wr(2'd1, 8'd4, 32'hFFFF_FFFB);
        wr(2'd2, 8'd4, 32'd7);
        wr(2'd3, 8'd0, 32'd77);   // class 3 ignored
        wr(2'd0, 8'd5, 32'd77);   // index beyond bias ignored
        frame4(c_FEATS, 4'b1000, 2);
        expect_score("bias_stall", c_BIAS);

        // Writes attempted during ACC must be ignored
        beat(16'd1, 1'b0);
        wr(2'd0, 8'd1, 32'd50);
        wr(2'd1, 8'd4, 32'd999);
        beat(16'd2, 1'b0);
        beat(16'd3, 1'b0);
        beat(16'd4, 1'b1);
        expect_score("wr_in_acc", c_BIAS);

        // Saturation / wrap
        for (int i = 0; i < N_IN; i++) begin
            wr(2'd0, 8'(i), 32'h7FFF);
            wr(2'd1, 8'(i), 32'h7FFF);
            wr(2'd2, 8'(i), 32'h7FFF);
        end
        wr(2'd0, 8'd4, 32'd0);
        wr(2'd1, 8'd4, 32'd0);
        wr(2'd2, 8'd4, 32'd0);
        frame4({4{16'h7FFF}}, 4'b1000, 0);
        expect_score("sat", c_SAT);

        // Reset in mid-frame
        s0 = sv_cnt;
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk96("midrst_score", score_data, 96'h0);
        chk1("midrst_valid", score_valid, 1'b0);
        chk1("midrst_err", frame_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        frame4(c_FEATS, 4'b1000, 0);
        expect_score("post_reset", 96'h0);
        chki("midrst_one_pulse", sv_cnt, s0 + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
